// File: rtl/ks10_spi_pkg.sv
// Shared definitions for the SPI serial engines.
package ks10_spi_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } spi_state_e;

   localparam logic SPI_IDLE_MOSI = 1'b1;
   localparam int   SPI_DIVW_DEF  = 8;

endpackage

// File: rtl/spi_halfper_cnt.sv
// Loadable half-period down-counter. It holds at zero and does not wrap.
module spi_halfper_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // Load has priority; otherwise count down and stop at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/spi_sclk_engine.sv
// Byte-serial SPI master, mode 0, with a registered divided serial clock.
//
// state | meaning
// IDLE  | sclk low, mosi idle-high, waiting for start
// LOW   | sclk low half-period; rising edge samples miso
// HIGH  | sclk high half-period; falling edge presents next tx bit
// DONE  | byte complete; next edge pulses done and publishes rx_data
module spi_sclk_engine
   import ks10_spi_pkg::*;
#(
   parameter int DIVW = SPI_DIVW_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [DIVW-1:0] div,
   input  logic            cs_req,
   input  logic            start,
   input  logic [7:0]      tx_data,
   output logic [7:0]      rx_data,
   output logic            busy,
   output logic            done,
   output logic            spi_sclk,
   output logic            spi_mosi,
   input  logic            spi_miso,
   output logic            spi_cs_n
);

   spi_state_e      state_q, state_d;
   logic [DIVW-1:0] div_q, div_d;
   logic [7:0]      tx_q, tx_d;
   logic [7:0]      rx_sr_q, rx_sr_d;
   logic [7:0]      rx_data_q, rx_data_d;
   logic [2:0]      bit_q, bit_d;
   logic            sclk_q, sclk_d;
   logic            mosi_q, mosi_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            cs_n_q;
   logic            cnt_load;
   logic [DIVW-1:0] cnt_val;
   logic            cnt_zero;

   spi_halfper_cnt #(.W(DIVW)) u_halfper (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .zero_o     (cnt_zero)
   );

   // Next-state and datapath decode. A start arriving while done is still
   // high belongs to the completion cycle and is dropped, not queued.
   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      tx_d      = tx_q;
      rx_sr_d   = rx_sr_q;
      rx_data_d = rx_data_q;
      bit_d     = bit_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      cnt_load  = 1'b0;
      cnt_val   = div_q;
      unique case (state_q)
         IDLE: begin
            sclk_d = 1'b0;
            mosi_d = SPI_IDLE_MOSI;
            if (start && !done_q) begin
               div_d    = div;
               tx_d     = tx_data;
               bit_d    = 3'd0;
               busy_d   = 1'b1;
               mosi_d   = tx_data[7];
               cnt_load = 1'b1;
               cnt_val  = div;
               state_d  = LOW;
            end
         end
         LOW: begin
            if (cnt_zero) begin
               sclk_d   = 1'b1;
               rx_sr_d  = {rx_sr_q[6:0], spi_miso};
               cnt_load = 1'b1;
               state_d  = HIGH;
            end
         end
         HIGH: begin
            if (cnt_zero) begin
               sclk_d   = 1'b0;
               cnt_load = 1'b1;
               if (bit_q == 3'd7) begin
                  state_d = DONE;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  mosi_d  = tx_q[6];
                  tx_d    = {tx_q[6:0], 1'b0};
                  state_d = LOW;
               end
            end
         end
         DONE: begin
            done_d    = 1'b1;
            busy_d    = 1'b0;
            rx_data_d = rx_sr_q;
            mosi_d    = SPI_IDLE_MOSI;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Transfer state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         div_q     <= '0;
         tx_q      <= 8'h00;
         rx_sr_q   <= 8'h00;
         rx_data_q <= 8'h00;
         bit_q     <= 3'd0;
         sclk_q    <= 1'b0;
         mosi_q    <= SPI_IDLE_MOSI;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         tx_q      <= tx_d;
         rx_sr_q   <= rx_sr_d;
         rx_data_q <= rx_data_d;
         bit_q     <= bit_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Chip select tracks the request independently of the transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_n_q <= 1'b1;
      end else begin
         cs_n_q <= ~cs_req;
      end
   end

   assign rx_data  = rx_data_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign spi_sclk = sclk_q;
   assign spi_mosi = mosi_q;
   assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Directed bench for spi_sclk_engine.
module tb_spi_sclk_engine;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] div_r = 8'd0;
   logic       cs_req = 1'b0;
   logic       start = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic [7:0] rx_data;
   logic       busy;
   logic       done;
   logic       spi_sclk;
   logic       spi_mosi;
   logic       tb_miso = 1'b0;
   logic       spi_cs_n;

   int errors = 0;
   int checks = 0;
   int done_seen = 0;

   spi_sclk_engine #(.DIVW(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .div      (div_r),
      .cs_req   (cs_req),
      .start    (start),
      .tx_data  (tx_data),
      .rx_data  (rx_data),
      .busy     (busy),
      .done     (done),
      .spi_sclk (spi_sclk),
      .spi_mosi (spi_mosi),
      .spi_miso (tb_miso),
      .spi_cs_n (spi_cs_n)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (done === 1'b1) done_seen++;

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++; if (spi_sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b want 0", spi_sclk); end
      checks++; if (spi_mosi !== 1'b1) begin errors++; $display("FAIL reset_mosi got %b want 1", spi_mosi); end
      checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n got %b want 1", spi_cs_n); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx got %h want 00", rx_data); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      cs_req = 1'b1;
      @(posedge clk); #1;
      checks++; if (spi_cs_n !== 1'b0) begin errors++; $display("FAIL cs_assert got %b want 0", spi_cs_n); end
   endtask

   // One byte transfer, measured edge by edge from the accepting edge.
   task automatic xfer(input logic [7:0] d, input logic [7:0] tx, input bit loop,
                       input logic [7:0] model, input logic [7:0] exp_rx, input int exp_n,
                       input bit disturb, input bit cs_tog, input string name);
      int  n, hp, rises, badrun, runlen, bitidx, badmosi, d0;
      logic ps, pm;
      bit  got;
      hp = int'(d) + 1;
      d0 = done_seen;
      div_r = d; tx_data = tx; start = 1'b1;
      tb_miso = loop ? tx[7] : model[7];
      @(posedge clk); #1;
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_on got %b want 1", name, busy); end
      checks++; if (spi_mosi !== tx[7]) begin errors++; $display("FAIL %s first_mosi got %b want %b", name, spi_mosi, tx[7]); end
      if (loop) tb_miso = spi_mosi;
      ps = spi_sclk; pm = spi_mosi;
      runlen = 1; rises = 0; badrun = 0; bitidx = 0; badmosi = 0; got = 0; n = 0;
      while (!got && n < 2000) begin
         if (disturb && n == 10) begin start = 1'b1; div_r = 8'd7; end
         if (disturb && n == 11) start = 1'b0;
         if (cs_tog && n == 20) cs_req = 1'b0;
         if (cs_tog && n == 30) cs_req = 1'b1;
         @(posedge clk); #1;
         n++;
         if (cs_tog && n == 21) begin
            checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL %s cs_deassert got %b want 1", name, spi_cs_n); end
         end
         if (cs_tog && n == 31) begin
            checks++; if (spi_cs_n !== 1'b0) begin errors++; $display("FAIL %s cs_reassert got %b want 0", name, spi_cs_n); end
         end
         if (done === 1'b1) begin
            got = 1;
         end else if (spi_sclk !== ps) begin
            if (runlen != hp) badrun++;
            if (spi_sclk === 1'b1) rises++;
            else bitidx++;
            runlen = 1;
         end else begin
            runlen++;
         end
         if (spi_mosi !== pm && !(ps === 1'b1 && spi_sclk === 1'b0) && done !== 1'b1) badmosi++;
         ps = spi_sclk; pm = spi_mosi;
         if (loop) tb_miso = spi_mosi;
         else if (bitidx < 8) tb_miso = model[7 - bitidx];
      end
      checks++; if (!got || n != exp_n) begin errors++; $display("FAIL %s latency got %0d want %0d", name, n, exp_n); end
      checks++; if (rx_data !== exp_rx) begin errors++; $display("FAIL %s rx_data got %h want %h", name, rx_data, exp_rx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done got %b want 0", name, busy); end
      checks++; if (rises != 8) begin errors++; $display("FAIL %s sclk_rises got %0d want 8", name, rises); end
      checks++; if (badrun != 0) begin errors++; $display("FAIL %s half_period bad_runs got %0d want 0 (hp %0d)", name, badrun, hp); end
      checks++; if (badmosi != 0) begin errors++; $display("FAIL %s mosi_off_fall got %0d want 0", name, badmosi); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done_width got %b want 0", name, done); end
      checks++; if (spi_mosi !== 1'b1 || spi_sclk !== 1'b0) begin errors++; $display("FAIL %s idle_lines got mosi=%b sclk=%b want 1/0", name, spi_mosi, spi_sclk); end
      repeat (60) @(posedge clk);
      #1;
      checks++; if (done_seen - d0 != 1) begin errors++; $display("FAIL %s done_count got %0d want 1", name, done_seen - d0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_after got %b want 0", name, busy); end
   endtask

   task automatic test_loopback();
      xfer(8'd0, 8'hA5, 1'b1, 8'h00, 8'hA5, 17, 1'b0, 1'b0, "loop_div0");
   endtask

   task automatic test_model();
      xfer(8'd4, 8'h3C, 1'b0, 8'hC3, 8'hC3, 81, 1'b0, 1'b0, "model_div4");
   endtask

   task automatic test_ignore_start();
      xfer(8'd2, 8'h5A, 1'b1, 8'h00, 8'h5A, 49, 1'b1, 1'b0, "ignore_div2");
   endtask

   task automatic test_cs_toggle();
      xfer(8'd3, 8'h96, 1'b1, 8'h00, 8'h96, 65, 1'b0, 1'b1, "cs_toggle_div3");
   endtask

   task automatic test_back_to_back();
      int t[4];
      int cnt, badrx;
      cnt = 0; badrx = 0;
      div_r = 8'd1; tx_data = 8'h81; start = 1'b1; tb_miso = 1'b1;
      for (int n = 1; n <= 120; n++) begin
         @(posedge clk); #1;
         tb_miso = spi_mosi;
         if (done === 1'b1) begin
            if (cnt < 4) t[cnt] = n;
            cnt++;
            if (rx_data !== 8'h81) badrx++;
         end
      end
      start = 1'b0;
      checks++; if (cnt != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", cnt); end
      if (cnt >= 3) begin
         checks++; if (t[0] != 34) begin errors++; $display("FAIL b2b_first got %0d want 34", t[0]); end
         checks++; if (t[1] - t[0] != 35) begin errors++; $display("FAIL b2b_period1 got %0d want 35", t[1] - t[0]); end
         checks++; if (t[2] - t[1] != 35) begin errors++; $display("FAIL b2b_period2 got %0d want 35", t[2] - t[1]); end
      end
      checks++; if (badrx != 0) begin errors++; $display("FAIL b2b_rx bad_bytes got %0d want 0", badrx); end
      repeat (50) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle busy got %b want 0", busy); end
   endtask

   task automatic test_reset_mid();
      int d0;
      div_r = 8'd3; tx_data = 8'h00; start = 1'b1; cs_req = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checks++; if (spi_sclk !== 1'b1 || spi_mosi !== 1'b0) begin errors++; $display("FAIL rstmid_pre got sclk=%b mosi=%b want 1/0", spi_sclk, spi_mosi); end
      d0 = done_seen;
      rst_n = 1'b0;
      #1;
      checks++; if (spi_sclk !== 1'b0) begin errors++; $display("FAIL rstmid_sclk got %b want 0", spi_sclk); end
      checks++; if (spi_mosi !== 1'b1) begin errors++; $display("FAIL rstmid_mosi got %b want 1", spi_mosi); end
      checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL rstmid_cs_n got %b want 1", spi_cs_n); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
      #20;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      checks++; if (done_seen != d0) begin errors++; $display("FAIL rstmid_no_done got %0d want 0", done_seen - d0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_after got %b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_model();
      test_ignore_start();
      test_cs_toggle();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_sclk_engine.md
# spi_sclk_engine

Byte-serial SPI master (mode 0) for the SD-card disk emulation path. It divides the system clock down to a registered, glitch-free serial clock `spi_sclk`, shifts one byte out on `spi_mosi` and one byte in from `spi_miso` per transfer, and reports completion with a single-cycle pulse. `spi_sclk` is a plain fabric register output. It feeds directly into the clock-forwarding pad stage, which drives it off-chip, so it must never toggle faster than one level per `clk` cycle and must never glitch.

## Interface
Parameters:
- `DIVW`, default 8: width of the half-period divisor.

Ports:
- `clk` input, 1: system clock; all logic is on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `div` input, DIVW: half-period of `spi_sclk` in `clk` cycles, minus 1. Latched when `start` is accepted.
- `cs_req` input, 1: chip-select request. Registered to `spi_cs_n = ~cs_req`, independent of the transfer state.
- `start` input, 1: begin a byte transfer. Accepted only while `busy` = 0.
- `tx_data` input, 8: byte to send, MSB first. Latched when `start` is accepted.
- `rx_data` output, 8: received byte. Valid from the `done` pulse until the next accepted `start`.
- `busy` output, 1: transfer in progress.
- `done` output, 1: one-cycle completion pulse.
- `spi_sclk` output, 1: serial clock; goes to the clock-forwarding stage.
- `spi_mosi` output, 1: serial data out.
- `spi_miso` input, 1: serial data in. Externally synchronous to `spi_sclk`; sampled without a synchronizer.
- `spi_cs_n` output, 1: active-low chip select.

## Operation
- Reset values (asynchronous on `rst_n` = 0):
  - `spi_sclk` = 0, `spi_mosi` = 1, `spi_cs_n` = 1
  - `busy` = 0, `done` = 0, `rx_data` = 8'h00
  - state = IDLE, all counters = 0
- States:
  - IDLE: `spi_sclk` = 0, `spi_mosi` = 1. `start` → LOW. On that edge: latch `div` and `tx_data`, load the half-period counter with `div`, set bit count = 0, set `busy` = 1, drive `spi_mosi` = `tx_data[7]`.
  - LOW: `spi_sclk` = 0. The counter decrements each cycle. When the counter = 0:
    - set `spi_sclk` = 1
    - shift `spi_miso` into the rx shift register LSB
    - reload the counter with `div`
    - → HIGH
  - HIGH: `spi_sclk` = 1. The counter decrements each cycle. When the counter = 0:
    - set `spi_sclk` = 0 and reload the counter
    - if bit count = 7: → DONE
    - else: increment bit count, drive the next tx bit on `spi_mosi`, → LOW
  - DONE: for exactly one cycle:
    - `done` = 1, `busy` = 0
    - `rx_data` = rx shift register
    - `spi_mosi` = 1
    - → IDLE
- A `start` during LOW, HIGH or DONE is ignored; it is not queued.
- The latched divisor governs the whole byte. Changing `div` mid-transfer has no effect.
- `div` = 0 gives `spi_sclk` = `clk`/2, the fastest rate.
- The counter is DIVW bits and has no wrap-around hazard, because it is reloaded at 0 and never decremented past 0.
- Back-to-back transfers: `start` asserted in the DONE cycle is ignored. It is accepted on the following cycle (IDLE).
- Reset mid-transfer: outputs return to reset values immediately. The partial byte is lost and no `done` is produced.

## Timing
- Accepted `start` at edge 0:
  - `busy` = 1 and `spi_mosi` valid after edge 0
  - first `spi_sclk` rise after edge (div+1)
- Each `spi_sclk` half-period is exactly div+1 `clk` cycles. Duty cycle is exactly 50%.
- `done` is high in the cycle following edge 16·(div+1)+1.
- Total transfer latency from `start` to `done` = 16·(div+1)+1 cycles.
- `spi_mosi` changes only on a falling `spi_sclk` edge, or at start. `spi_miso` is sampled only on the rising edge.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Shared package `ks10_spi_pkg`:
  - state enum IDLE/LOW/HIGH/DONE
  - constant `SPI_IDLE_MOSI` = 1'b1
  - default `DIVW` = 8
- One natural sub-module: `spi_halfper_cnt`, a loadable down-counter with a zero flag. It is reused by other serial engines.
- The tx and rx shift registers and the bit counter stay in the top module.

## Test plan
- Reset mid-transfer: `rst_n` low at cycle 5 of a `div`=3 byte → `spi_sclk`=0, `spi_mosi`=1, `spi_cs_n`=1 and `busy`=0 immediately; `done` never pulses.
- Loopback, `div`=0, `tx_data`=8'hA5, `spi_miso` tied to `spi_mosi` → `done` at cycle 17, `rx_data`=8'hA5, 8 rising edges on `spi_sclk`, each period 2 cycles.
- `div`=4, `tx_data`=8'h3C, `spi_miso` driven from model byte 8'hC3 → `done` at cycle 81, `rx_data`=8'hC3, each half-period 5 cycles.
- `start` pulsed at cycle 10 of a busy transfer, and `div` changed from 2 to 7 mid-byte → only one `done`, timing unchanged (49 cycles).
- `start` held high continuously with `div`=1 → `done` pulses every 35 cycles: 33 cycles of transfer, plus the DONE cycle, plus 1 IDLE cycle.
- `cs_req` toggled during a transfer → `spi_cs_n` follows one cycle later; `spi_sclk` and the data are unaffected.
